// File: rtl/a2_bridge_seq.sv
// a2_bridge_seq: per-bus-cycle sequencer for the A2Bridge multiplexed transceiver.
// Steps address low/high/control captures, then either samples write data or drives read data.
module a2_bridge_seq #(
  parameter int ADDR_DELAY          = 2,
  parameter int SETTLE_CYCLES       = 3,
  parameter int WRITE_SAMPLE        = 18,
  parameter int BUS_DATA_OUT_ENABLE = 1
) (
  input  logic        clk_logic,
  input  logic        reset,
  input  logic        phi1_posedge_i,
  input  logic        phi1_negedge_i,
  output logic [1:0]  a2_bridge_sel_o,
  output logic        a2_bridge_bus_a_oe_o,
  output logic        a2_bridge_bus_d_oe_o,
  output logic        a2_bridge_rd_o,
  output logic        a2_bridge_wr_o,
  input  logic [7:0]  a2_bridge_d_i,
  output logic [7:0]  a2_bridge_d_o,
  output logic        a2_bridge_d_oe_o,
  input  logic        data_out_en_i,
  input  logic [7:0]  data_out_i,
  output logic [15:0] addr_o,
  output logic [7:0]  ctrl_o,
  output logic        addr_valid_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        overrun_o
);

  localparam int CMAX = (ADDR_DELAY > SETTLE_CYCLES) ? ADDR_DELAY : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int NCW  = $clog2(WRITE_SAMPLE + 2);
  localparam logic [CW-1:0]  DELAY_LAST  = CW'(ADDR_DELAY - 1);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES);
  localparam logic [NCW-1:0] WR_START    = NCW'(WRITE_SAMPLE);
  localparam bit             DRIVE_EN    = (BUS_DATA_OUT_ENABLE != 0);

  typedef enum logic [3:0] {
    S_IDLE, S_DELAY, S_CAP_LO, S_CAP_HI, S_CAP_CTRL,
    S_WAIT_PHI0, S_WR_WAIT, S_CAP_DATA, S_DRIVE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCW-1:0] ncnt_q, ncnt_d;
  logic           in_phi0_q, in_phi0_d;
  logic [1:0]     sel_q, sel_d;
  logic           a_oe_q, a_oe_d;
  logic           d_oe_q, d_oe_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic           pad_oe_q, pad_oe_d;
  logic [7:0]     dout_q, dout_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     ctrl_q, ctrl_d;
  logic           avld_q, avld_d;
  logic [7:0]     data_q, data_d;
  logic           dvld_q, dvld_d;
  logic           ovr_q, ovr_d;
  logic           cap_done;

  assign cap_done = (cnt_q == SETTLE_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ctrl_d    = ctrl_q;
    data_d    = data_q;
    ovr_d     = ovr_q;
    avld_d    = 1'b0;
    dvld_d    = 1'b0;
    in_phi0_d = in_phi0_q;
    ncnt_d    = ncnt_q;

    // in_phi0 spans negedge..posedge; ncnt counts cycles since the last negedge
    if (phi1_posedge_i)      in_phi0_d = 1'b0;
    else if (phi1_negedge_i) in_phi0_d = 1'b1;
    if (phi1_negedge_i)                          ncnt_d = NCW'(1);
    else if (ncnt_q != '0 && ncnt_q != '1)       ncnt_d = ncnt_q + 1'b1;

    if (phi1_posedge_i) begin
      // A new bus cycle always restarts; only an unfinished sequence counts as overrun
      state_d = S_DELAY;
      cnt_d   = '0;
      if (state_q != S_IDLE && state_q != S_DRIVE) ovr_d = 1'b1;
    end else begin
      case (state_q)
        S_DELAY: begin
          if (cnt_q == DELAY_LAST) begin
            state_d = S_CAP_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CAP_LO: begin
          if (cap_done) begin
            addr_d[7:0] = a2_bridge_d_i;
            state_d     = S_CAP_HI;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CAP_HI: begin
          if (cap_done) begin
            addr_d[15:8] = a2_bridge_d_i;
            state_d      = S_CAP_CTRL;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CAP_CTRL: begin
          if (cap_done) begin
            ctrl_d  = a2_bridge_d_i;
            avld_d  = 1'b1;
            state_d = S_WAIT_PHI0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_PHI0: begin
          if (in_phi0_q) begin
            if (!ctrl_q[0])                    state_d = S_WR_WAIT;
            else if (data_out_en_i && DRIVE_EN) state_d = S_DRIVE;
            else                                state_d = S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (ncnt_q >= WR_START) begin
            state_d = S_CAP_DATA;
            cnt_d   = '0;
          end
        end
        S_CAP_DATA: begin
          if (cap_done) begin
            data_d  = a2_bridge_d_i;
            dvld_d  = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Pin controls are decoded from the next state so every pin leaves a flop
    sel_d    = 2'b00;
    a_oe_d   = 1'b0;
    d_oe_d   = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    pad_oe_d = 1'b0;
    dout_d   = 8'h00;
    case (state_d)
      S_CAP_LO:   begin sel_d = 2'b00; a_oe_d = 1'b1; rd_d = 1'b1; end
      S_CAP_HI:   begin sel_d = 2'b01; a_oe_d = 1'b1; rd_d = 1'b1; end
      S_CAP_CTRL: begin sel_d = 2'b10; a_oe_d = 1'b1; rd_d = 1'b1; end
      S_CAP_DATA: begin sel_d = 2'b11; d_oe_d = 1'b1; rd_d = 1'b1; end
      S_DRIVE: begin
        sel_d    = 2'b11;
        d_oe_d   = 1'b1;
        wr_d     = 1'b1;
        pad_oe_d = 1'b1;
        dout_d   = data_out_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_logic) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ncnt_q    <= '0;
      in_phi0_q <= 1'b0;
      sel_q     <= 2'b00;
      a_oe_q    <= 1'b0;
      d_oe_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      pad_oe_q  <= 1'b0;
      dout_q    <= 8'h00;
      addr_q    <= 16'h0000;
      ctrl_q    <= 8'hFF;
      avld_q    <= 1'b0;
      data_q    <= 8'h00;
      dvld_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ncnt_q    <= ncnt_d;
      in_phi0_q <= in_phi0_d;
      sel_q     <= sel_d;
      a_oe_q    <= a_oe_d;
      d_oe_q    <= d_oe_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      pad_oe_q  <= pad_oe_d;
      dout_q    <= dout_d;
      addr_q    <= addr_d;
      ctrl_q    <= ctrl_d;
      avld_q    <= avld_d;
      data_q    <= data_d;
      dvld_q    <= dvld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign a2_bridge_sel_o      = sel_q;
  assign a2_bridge_bus_a_oe_o = a_oe_q;
  assign a2_bridge_bus_d_oe_o = d_oe_q;
  assign a2_bridge_rd_o       = rd_q;
  assign a2_bridge_wr_o       = wr_q;
  assign a2_bridge_d_o        = dout_q;
  assign a2_bridge_d_oe_o     = pad_oe_q;
  assign addr_o               = addr_q;
  assign ctrl_o               = ctrl_q;
  assign addr_valid_o         = avld_q;
  assign data_o               = data_q;
  assign data_valid_o         = dvld_q;
  assign overrun_o            = ovr_q;

endmodule
